// File: rtl/exp_add_arb_pkg.sv
// Shared FPU definitions for the exponent-add arbiter: default exponent width
// and the 1-bit requester id.
package exp_add_arb_pkg;

    localparam int EXP_W = 14;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/exp_add.sv
// Exponent prefix adder (Kogge-Stone), sum = a + b + cin, with carry-out.
// The carry-in is treated as the generate bit of position -1.
module exp_add
    import exp_add_arb_pkg::*;
#(
    parameter int WIDTH = EXP_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int LV = $clog2(WIDTH + 1);

    logic [WIDTH:0] g, p, gn, pn;

    always_comb begin
        g  = {a & b, cin};
        p  = {a ^ b, 1'b0};
        gn = g;
        pn = p;
        for (int l = 0; l < LV; l++) begin
            gn = g;
            pn = p;
            for (int i = (1 << l); i <= WIDTH; i++) begin
                gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                pn[i] = p[i] & p[i - (1 << l)];
            end
            g = gn;
            p = pn;
        end
        // g[i] is now the carry into operand bit i.
        sum  = (a ^ b) ^ g[WIDTH-1:0];
        cout = g[WIDTH];
    end

endmodule

// File: rtl/exp_add_arb.sv
// Two-requester round-robin front end sharing one exponent adder; each
// requester has at most one operation in flight, answered two cycles later.
module exp_add_arb
    import exp_add_arb_pkg::*;
#(
    parameter int WIDTH = EXP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req0_cin,
    input  logic             req1_cin,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp0_sum,
    output logic [WIDTH-1:0] rsp1_sum,
    output logic             rsp0_cout,
    output logic             rsp1_cout,
    output logic             busy
);
    // vld_pipe[0]: operands in S1; vld_pipe[STAGES]: result captured, valid next.
    localparam int STAGES = 1;

    logic [1:0]            vld, rdy, acc, elig, inflight, rsp_vld, rsp_rdy, rsp_hs, rsp_cout;
    logic [1:0][WIDTH-1:0] rsp_sum;
    req_id_t               ptr, acc_id;
    logic [STAGES:0]       vld_pipe;
    req_id_t [STAGES:0]    id_pipe;
    logic [WIDTH-1:0]      s1_a, s1_b, add_sum;
    logic                  s1_cin, add_cout;

    always_comb begin
        vld     = {req1_valid, req0_valid};
        rsp_rdy = {rsp1_ready, rsp0_ready};
        elig    = ~inflight;
        rdy[0]  = elig[0] & ((ptr == REQ0) | ~(vld[1] & elig[1]));
        rdy[1]  = elig[1] & ((ptr == REQ1) | ~(vld[0] & elig[0]));
        acc     = vld & rdy;
        acc_id  = acc[1] ? REQ1 : REQ0;
        rsp_hs  = rsp_vld & rsp_rdy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
            ptr      <= REQ0;
            vld_pipe <= '0;
            id_pipe  <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
        end else begin
            inflight <= (inflight & ~rsp_hs) | acc;
            vld_pipe <= {vld_pipe[STAGES-1:0], |acc};
            id_pipe  <= {id_pipe[STAGES-1:0], acc_id};
            if (|acc) begin
                ptr    <= ~acc_id;
                s1_a   <= acc[1] ? req1_a   : req0_a;
                s1_b   <= acc[1] ? req1_b   : req0_b;
                s1_cin <= acc[1] ? req1_cin : req0_cin;
            end
        end
    end

    exp_add #(.WIDTH(WIDTH)) u_add (
        .a    (s1_a),
        .b    (s1_b),
        .cin  (s1_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Owner is inflight until its handshake, so its result register cannot be
    // overwritten while rsp_valid is up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_vld  <= '0;
            rsp_sum  <= '0;
            rsp_cout <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (vld_pipe[0] && id_pipe[0] == req_id_t'(i)) begin
                    rsp_sum[i]  <= add_sum;
                    rsp_cout[i] <= add_cout;
                end
                if (vld_pipe[STAGES] && id_pipe[STAGES] == req_id_t'(i))
                    rsp_vld[i] <= 1'b1;
                else if (rsp_hs[i])
                    rsp_vld[i] <= 1'b0;
            end
        end
    end

    assign req0_ready = rdy[0];
    assign req1_ready = rdy[1];
    assign rsp0_valid = rsp_vld[0];
    assign rsp1_valid = rsp_vld[1];
    assign rsp0_sum   = rsp_sum[0];
    assign rsp1_sum   = rsp_sum[1];
    assign rsp0_cout  = rsp_cout[0];
    assign rsp1_cout  = rsp_cout[1];
    assign busy       = |inflight;

endmodule

// File: doc/exp_add_arb.md
EXP_ADD_ARB -- requirements
Module: exp_add_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 14, giving the exponent operand and sum width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1  the requester presents an operation.
REQ-005 SHALL have ports req0_ready, req1_ready  output  1  the arbiter accepts the operation this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  the operands.
REQ-007 SHALL have ports req0_cin, req1_cin  input  1  the carry-in.
REQ-008 SHALL have ports rsp0_valid, rsp1_valid  output  1  a result is held for the requester.
REQ-009 SHALL have ports rsp0_ready, rsp1_ready  input  1  the requester consumes the result.
REQ-010 SHALL have ports rsp0_sum, rsp1_sum  output  WIDTH  the sum, a+b+cin mod 2^WIDTH.
REQ-011 SHALL have ports rsp0_cout, rsp1_cout  output  1  the carry-out of the sum.
REQ-012 SHALL have port busy  output  1  high while any operation is in flight or unconsumed.

Function
REQ-013 SHALL share one adder instance between two requesters; an accept is valid&ready on the same edge.
REQ-014 SHALL keep per-requester inflight[i]: set on accept, cleared on the rsp_i handshake (rsp_i_valid&rsp_i_ready).
REQ-015 SHALL set eligible[i] = !inflight[i]; a cleared inflight bit makes the requester eligible only from the next cycle.
REQ-016 SHALL keep a round-robin pointer ptr; req_i_ready = eligible[i] & (ptr==i | !(req_other_valid & eligible[other])).
REQ-017 SHALL make req_i_ready independent of req_i_valid.
REQ-018 SHALL accept at most one operation per cycle.
REQ-019 SHALL set ptr to the non-granted requester after every accept; with no accept, ptr holds.
REQ-020 SHALL register the accepted a, b, cin and the owner id in issue stage S1 on the accept edge.
REQ-021 SHALL apply the S1 operands combinationally to the adder, then capture sum/cout into the owner's response register on the next edge.
REQ-022 SHALL raise rsp_i_valid exactly 2 cycles after the accept edge (latency 2).
REQ-023 SHALL hold rsp_i_valid, sum and cout stable until the rsp_i handshake, then drop rsp_i_valid on the following edge.
REQ-024 SHALL let backpressure on one response channel stall only that requester; the other requester keeps full service.
REQ-025 SHALL assert busy = inflight[0] | inflight[1].

Reset
REQ-026 SHALL, while reset is low, force:
- inflight and S1 valid to 0
- ptr to requester 0
- rsp0_valid, rsp1_valid and busy to 0
- sum and cout registers to 0
REQ-027 SHALL discard any operation in S1 or unconsumed when reset asserts mid-operation, with no later response for it.
REQ-028 SHALL make req0_ready and req1_ready equal 1 in the first cycle after reset release.

Structure
REQ-029 SHALL take the WIDTH default (14) and a 1-bit requester-id type from the shared FPU package.
REQ-030 SHALL instantiate the existing 14-bit prefix adder exp_add as the only sub-module.
REQ-031 SHALL contain no other arithmetic.
REQ-032 SHALL be 120-400 lines of RTL.

Verification
REQ-033 SHALL check reset: hold reset low with req0_valid=1 -> rsp*_valid=0, busy=0; first cycle after release -> req0_ready=1, req1_ready=1.
REQ-034 SHALL check a single operation: req0 a=0x0005, b=0x0003, cin=1 accepted at edge N -> rsp0_valid=1 after edge N+2, rsp0_sum=0x0009, rsp0_cout=0.
REQ-035 SHALL check wrap-around: req1 a=0x3FFF, b=0x0001, cin=0 -> rsp1_sum=0x0000, rsp1_cout=1.
REQ-036 SHALL check simultaneous requests after reset, both valid:
- req0 accepted first, req1 accepted on the next edge
- with rsp ready held high, the second req0 is accepted after req0's inflight clears, and ptr toggles 0,1,0
REQ-037 SHALL check backpressure:
- with rsp0_ready=0 for 5 cycles, rsp0 outputs stay stable and req0_ready=0
- req1 keeps completing operations
- raising rsp0_ready drains rsp0, and req0_ready=1 on the following cycle
REQ-038 SHALL check reset mid-operation: assert reset one cycle after a req0 accept -> no rsp0_valid ever appears for that operation, and busy=0.
